// File: rtl/pinpad_pkg.sv
// Shared types and helpers for the pinpad keypad scanner.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: scan_state_t, key code constants, column/row idle patterns,
// one-cold helpers and the 4x4 key code lookup.
package pinpad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_DEB_PRESS = 3'd2,
    ST_WAIT_REL  = 3'd3,
    ST_DONE      = 3'd4
  } scan_state_t;

  localparam logic [3:0] KEY_STAR     = 4'd14;
  localparam logic [3:0] KEY_HASH     = 4'd15;
  localparam logic [3:0] COL_IDLE     = 4'b1111;
  // Rows are pulled up externally, so an unpressed pad reads all ones.
  localparam logic [3:0] ROW_RELEASED = 4'b1111;

  // True when exactly one bit of an active-low vector is asserted.
  function automatic logic is_one_cold(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Index of the single low bit; only meaningful when is_one_cold(v).
  function automatic logic [1:0] cold_index(input logic [3:0] v);
    case (v)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Physical layout:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'd1;
      4'h1: return 4'd2;
      4'h2: return 4'd3;
      4'h3: return 4'd10;
      4'h4: return 4'd4;
      4'h5: return 4'd5;
      4'h6: return 4'd6;
      4'h7: return 4'd11;
      4'h8: return 4'd7;
      4'h9: return 4'd8;
      4'hA: return 4'd9;
      4'hB: return 4'd12;
      4'hC: return KEY_STAR;
      4'hD: return 4'd0;
      4'hE: return KEY_HASH;
      default: return 4'd13;
    endcase
  endfunction

endpackage

// File: rtl/pinpad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Latency: 2 clk_50 cycles from row to row_s.
// Backpressure: none; free-running.
// Ports: clk_50, reset (sync, active-high), row[3:0] in, row_s[3:0] out.
module pinpad_row_sync
  import pinpad_pkg::*;
(
  input  logic       clk_50,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] row_s
);

  logic [3:0] row_meta;

  // Reset to the released pattern so nothing looks pressed out of reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      row_meta <= ROW_RELEASED;
      row_s    <= ROW_RELEASED;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

endmodule

// File: rtl/pinpad_keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce; returns one key code per request.
// Latency: done pulses DEBOUNCE_TICKS+1 cycles after the synchronized rows go idle.
// Backpressure: none; req is a level sampled in IDLE/SCAN, done is a 1-cycle pulse.
// Ports: clk_50, reset (sync, active-high), req, row[3:0] (async, active-low),
//        column[3:0] (active-low one-cold drive), num[3:0] (key code), done.
module pinpad_keypad_scanner
  import pinpad_pkg::*;
#(
  parameter int SCAN_TICKS     = 2500,
  parameter int DEBOUNCE_TICKS = 500000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] num,
  output logic       done
);

  localparam int DWELL_W = $clog2(SCAN_TICKS);
  localparam int STAB_W  = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_TICKS - 1);
  // Press: DEBOUNCE_TICKS matching cycles after capture, exit on the last one.
  localparam logic [STAB_W-1:0]  PRESS_LAST = STAB_W'(DEBOUNCE_TICKS - 1);
  // Release: count up to DEBOUNCE_TICKS, then exit, so done lands
  // DEBOUNCE_TICKS+1 cycles after the first idle row_s cycle.
  localparam logic [STAB_W-1:0]  REL_LAST   = STAB_W'(DEBOUNCE_TICKS);

  logic [3:0] row_s;

  pinpad_row_sync u_row_sync (
    .clk_50 (clk_50),
    .reset  (reset),
    .row    (row),
    .row_s  (row_s)
  );

  scan_state_t        state, state_nxt;
  logic [1:0]         col_idx, col_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic [STAB_W-1:0]  stab_cnt, stab_nxt;
  logic [3:0]         cap_pat, cap_pat_nxt;
  logic [3:0]         cap_code, cap_code_nxt;
  logic [3:0]         column_nxt;

  always_comb begin
    state_nxt    = state;
    col_nxt      = col_idx;
    dwell_nxt    = dwell_cnt;
    stab_nxt     = stab_cnt;
    cap_pat_nxt  = cap_pat;
    cap_code_nxt = cap_code;

    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt = ST_SCAN;
          col_nxt   = 2'd0;
          dwell_nxt = '0;
          stab_nxt  = '0;
        end
      end

      ST_SCAN: begin
        if (!req) begin
          state_nxt = ST_IDLE;
          dwell_nxt = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          // Ghosting or multi-key presses show up as several low rows; skip them.
          if (is_one_cold(row_s)) begin
            state_nxt    = ST_DEB_PRESS;
            cap_pat_nxt  = row_s;
            cap_code_nxt = key_code(cold_index(row_s), col_idx);
            stab_nxt     = '0;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + DWELL_W'(1);
        end
      end

      ST_DEB_PRESS: begin
        if (row_s != cap_pat) begin
          state_nxt = ST_SCAN;
          col_nxt   = col_idx + 2'd1;
          dwell_nxt = '0;
          stab_nxt  = '0;
        end else if (stab_cnt == PRESS_LAST) begin
          state_nxt = ST_WAIT_REL;
          stab_nxt  = '0;
        end else begin
          stab_nxt = stab_cnt + STAB_W'(1);
        end
      end

      ST_WAIT_REL: begin
        if (row_s != ROW_RELEASED) begin
          stab_nxt = '0;
        end else if (stab_cnt == REL_LAST) begin
          state_nxt = ST_DONE;
          stab_nxt  = '0;
        end else begin
          stab_nxt = stab_cnt + STAB_W'(1);
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        dwell_nxt = '0;
        stab_nxt  = '0;
      end
    endcase

    // Column lines are registered from the next state so the pad never sees glitches.
    case (state_nxt)
      ST_SCAN, ST_DEB_PRESS, ST_WAIT_REL: column_nxt = ~(4'b0001 << col_nxt);
      default:                            column_nxt = COL_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      col_idx   <= 2'd0;
      dwell_cnt <= '0;
      stab_cnt  <= '0;
      cap_pat   <= ROW_RELEASED;
      cap_code  <= 4'hF;
      column    <= COL_IDLE;
      num       <= 4'hF;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      dwell_cnt <= dwell_nxt;
      stab_cnt  <= stab_nxt;
      cap_pat   <= cap_pat_nxt;
      cap_code  <= cap_code_nxt;
      column    <= column_nxt;
      done      <= (state_nxt == ST_DONE);
      // num changes together with done so it is already valid in the pulse cycle.
      if (state_nxt == ST_DONE) begin
        num <= cap_code_nxt;
      end
    end
  end

endmodule
